// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the F/D, D/E and E/M pipeline registers: forwarding selects,
// load-use and branch handling, multi-cycle MDU hold sequencing and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 16,
  parameter logic [1:0]  LOAD_CODE   = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rs1_e_i,
  input  logic [4:0]       rs2_e_i,
  input  logic [4:0]       rd_e_i,
  input  logic [1:0]       res_src_e_i,
  input  logic             reg_write_m_i,
  input  logic [4:0]       rd_m_i,
  input  logic             reg_write_w_i,
  input  logic [4:0]       rd_w_i,
  input  logic             pc_src_e_i,
  input  logic             mdu_start_e_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             bubble_m_o,
  output logic [1:0]       fwd_a_e_o,
  output logic [1:0]       fwd_b_e_o,
  output logic             mdu_busy_o,
  output logic             mdu_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam int unsigned MW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
  // BUSY lasts MDU_LATENCY-2 cycles, so the op occupies E for MDU_LATENCY cycles in total.
  localparam logic [MW-1:0] BusyLoad = (MDU_LATENCY > 2) ? MW'(MDU_LATENCY - 3) : '0;

  state_e           r_state;
  logic [MW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu;
  logic w_start;
  logic w_hold;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs)) begin
      return 2'b10;
    end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign fwd_a_e_o = fwd_sel(rs1_e_i, reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i);
  assign fwd_b_e_o = fwd_sel(rs2_e_i, reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i);

  assign w_lu = (res_src_e_i == LOAD_CODE) && (rd_e_i != 5'd0) &&
                ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  assign w_start = (r_state == StIdle) && mdu_start_e_i && !pc_src_e_i;
  assign w_hold  = (r_state == StBusy) || w_start;

  always_comb begin
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    stall_e_o  = 1'b0;
    flush_d_o  = 1'b0;
    flush_e_o  = 1'b0;
    bubble_m_o = 1'b0;
    if (w_hold) begin
      stall_f_o  = 1'b1;
      stall_d_o  = 1'b1;
      stall_e_o  = 1'b1;
      bubble_m_o = 1'b1;
    end else if (pc_src_e_i) begin
      // A redirect must not be held, so it overrides load-use.
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (w_lu) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign mdu_busy_o  = (r_state == StBusy);
  assign mdu_done_o  = (r_state == StDone);
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (stall_f_o && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= (MDU_LATENCY > 2) ? StBusy : StDone;
            r_cnt   <= BusyLoad;
          end
        end
        StBusy: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - MW'(1);
          end else begin
            r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs, a negedge
// monitor pops and compares. A second instance with a 4-bit counter exercises saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] res_src_e;
  logic       reg_write_m, reg_write_w, pc_src_e, mdu_start_e;

  logic        stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, mdu_busy, mdu_done;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        s4_f, s4_d, s4_e, f4_d, f4_e, b4_m, busy4, done4;
  logic [1:0]  fa4, fb4;
  logic [3:0]  stall_cnt4;

  pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(16), .LOAD_CODE(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e),
    .rs2_e_i(rs2_e), .rd_e_i(rd_e), .res_src_e_i(res_src_e), .reg_write_m_i(reg_write_m),
    .rd_m_i(rd_m), .reg_write_w_i(reg_write_w), .rd_w_i(rd_w), .pc_src_e_i(pc_src_e),
    .mdu_start_e_i(mdu_start_e), .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e),
    .flush_d_o(flush_d), .flush_e_o(flush_e), .bubble_m_o(bubble_m), .fwd_a_e_o(fwd_a),
    .fwd_b_e_o(fwd_b), .mdu_busy_o(mdu_busy), .mdu_done_o(mdu_done), .stall_cnt_o(stall_cnt)
  );

  pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4), .LOAD_CODE(2'b01)) dut4 (
    .clk(clk), .rst_n(rst_n), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e),
    .rs2_e_i(rs2_e), .rd_e_i(rd_e), .res_src_e_i(res_src_e), .reg_write_m_i(reg_write_m),
    .rd_m_i(rd_m), .reg_write_w_i(reg_write_w), .rd_w_i(rd_w), .pc_src_e_i(pc_src_e),
    .mdu_start_e_i(mdu_start_e), .stall_f_o(s4_f), .stall_d_o(s4_d), .stall_e_o(s4_e),
    .flush_d_o(f4_d), .flush_e_o(f4_e), .bubble_m_o(b4_m), .fwd_a_e_o(fa4),
    .fwd_b_e_o(fb4), .mdu_busy_o(busy4), .mdu_done_o(done4), .stall_cnt_o(stall_cnt4)
  );

  // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, fwd_a, fwd_b, busy, done}
  typedef struct {
    string       name;
    logic [11:0] ctl;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt16 = 0;
  int   m_cnt4 = 0;

  localparam logic [11:0] C0   = 12'b0;
  localparam logic [11:0] CLU  = 12'b110010_00_00_00;
  localparam logic [11:0] CBR  = 12'b000110_00_00_00;
  localparam logic [11:0] CST  = 12'b111001_00_00_00;
  localparam logic [11:0] CBSY = 12'b111001_00_00_10;
  localparam logic [11:0] CDN  = 12'b000000_00_00_01;

  task automatic vec(input string nm, input logic rst, input logic [4:0] r1d, input logic [4:0] r2d,
                     input logic [4:0] r1e, input logic [4:0] r2e, input logic [4:0] rde,
                     input logic [1:0] rs, input logic wm, input logic [4:0] rdm,
                     input logic ww, input logic [4:0] rdw, input logic pcs, input logic mdu,
                     input logic [11:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; rs1_d = r1d; rs2_d = r2d; rs1_e = r1e; rs2_e = r2e; rd_e = rde;
    res_src_e = rs; reg_write_m = wm; rd_m = rdm; reg_write_w = ww; rd_w = rdw;
    pc_src_e = pcs; mdu_start_e = mdu;
    if (!rst) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end
    e.name  = nm;
    e.ctl   = ctl;
    e.cnt16 = 16'(m_cnt16);
    e.cnt4  = 4'(m_cnt4);
    exp_q.push_back(e);
    if (rst && ctl[11]) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [11:0] act;
      e = exp_q.pop_front();
      act = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, fwd_a, fwd_b,
             mdu_busy, mdu_done};
      n_cmp++;
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      n_cmp++;
      if (stall_cnt !== e.cnt16) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt16);
      end
      n_cmp++;
      if (stall_cnt4 !== e.cnt4) begin
        n_bad++;
        $display("FAIL %s stall_cnt4: got %0d expected %0d", e.name, stall_cnt4, e.cnt4);
      end
    end
  end

  initial begin
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    res_src_e = '0; reg_write_m = 1'b0; reg_write_w = 1'b0; pc_src_e = 1'b0;
    mdu_start_e = 1'b0;
    //   name          rst r1d r2d r1e r2e rde rs    wm rdm ww rdw pc mdu ctl
    vec("reset",       0,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("idle",        1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("fwd_m_prio",  1,  0,  0,  5,  0,  0,  2'd0, 1, 5,  1, 5,  0, 0,  12'b000000_10_00_00);
    vec("fwd_m_rd0",   1,  0,  0,  5,  0,  0,  2'd0, 1, 0,  1, 5,  0, 0,  12'b000000_01_00_00);
    vec("fwd_w_both",  1,  0,  0,  9,  9,  0,  2'd0, 0, 9,  1, 9,  0, 0,  12'b000000_01_01_00);
    vec("fwd_mb_wa",   1,  0,  0,  4,  6,  0,  2'd0, 1, 6,  1, 4,  0, 0,  12'b000000_01_10_00);
    vec("fwd_w_rd0",   1,  0,  0,  0,  0,  0,  2'd0, 1, 0,  1, 0,  0, 0,  C0);
    vec("lu_rs2",      1,  0,  7,  0,  0,  7,  2'd1, 0, 0,  0, 0,  0, 0,  CLU);
    vec("lu_rd0",      1,  0,  0,  0,  0,  0,  2'd1, 0, 0,  0, 0,  0, 0,  C0);
    vec("lu_rs1",      1,  3,  0,  0,  0,  3,  2'd1, 0, 0,  0, 0,  0, 0,  CLU);
    vec("no_load",     1,  3,  0,  0,  0,  3,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("lu_and_br",   1,  0,  7,  0,  0,  7,  2'd1, 0, 0,  0, 0,  1, 0,  CBR);
    vec("br_start",    1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  1, 1,  CBR);
    vec("after_brst",  1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("mdu_start",   1,  0,  7,  0,  0,  7,  2'd1, 0, 0,  0, 0,  0, 1,  CST);
    vec("mdu_busy1",   1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 1,  CBSY);
    vec("mdu_busy2",   1,  0,  7,  0,  0,  7,  2'd1, 0, 0,  0, 0,  1, 0,  CBSY);
    vec("mdu_done_lu", 1,  0,  7,  0,  0,  7,  2'd1, 0, 0,  0, 0,  0, 0,  CLU | CDN);
    vec("mdu_idle",    1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("mdu2_start",  1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 1,  CST);
    vec("mdu2_busy",   1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  CBSY);
    vec("rst_in_busy", 0,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("post_rst",    1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    for (int i = 0; i < 20; i++) begin
      vec("sat_lu",    1,  0,  7,  0,  0,  7,  2'd1, 0, 0,  0, 0,  0, 0,  CLU);
    end
    vec("sat_hold",    1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    vec("sat_hold2",   1,  0,  0,  0,  0,  0,  2'd0, 0, 0,  0, 0,  0, 0,  C0);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
